mem_arb: RTL

Single-port memory arbiter and sequencer. Shares one unified memory port between the instruction-fetch requester and the execute stage's data-access requester (address from the ALU result, write data from rs2). Each requester holds its request until accepted. The block registers the winning request, drives it onto the memory port with a valid/ready handshake, and routes the read response back to its owner. Only one transaction is outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_if.sv | 52 +++++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arb.sv | 97 +++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } own_e;

  localparam logic [3:0] READ_MASK = 4'hF;
  // Wide enough for DSTREAK up to 15.
  localparam int         STREAK_W  = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter, bundled for port lists.
interface mem_arb_if;

  // fetch requester
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_rdy;
  logic        o_if_rvld;
  logic [31:0] o_if_rdata;
  // data requester
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_mask;
  logic        o_d_rdy;
  logic        o_d_rvld;
  logic [31:0] o_d_rdata;
  // memory port
  logic        o_mem_vld;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rdy;
  logic        i_mem_rvld;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  // Arbiter side.
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_rdy, o_if_rvld, o_if_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_mask,
    output o_d_rdy, o_d_rvld, o_d_rdata,
    output o_mem_vld, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_rdy, i_mem_rvld, i_mem_rdata,
    output o_busy
  );

  // Requesters plus memory, seen from outside the arbiter.
  modport master (
    output i_if_req, i_if_addr,
    input  o_if_rdy, o_if_rvld, o_if_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_mask,
    input  o_d_rdy, o_d_rvld, o_d_rdata,
    input  o_mem_vld, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_rdy, i_mem_rvld, i_mem_rdata,
    input  o_busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select: data wins unless fetch is alone or has waited through
// DSTREAK consecutive data grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int DSTREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_gnt_if,
  output logic o_gnt_d
);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                sat;

  assign sat      = (streak_q == STREAK_W'(DSTREAK));
  assign o_gnt_d  = i_idle && i_d_req && !(i_if_req && sat);
  assign o_gnt_if = i_idle && i_if_req && !o_gnt_d;

  // Streak counts data grants that starved a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (i_idle) begin
      if (!i_if_req || o_gnt_if)
        streak_d = '0;
      else if (o_gnt_d && !sat)
        streak_d = streak_q + 1'b1;
    end
  end

  // Streak register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) streak_q <= '0;
    else          streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter: grants one requester, drives one transaction
// onto the memory port and routes the read response back to its owner.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int DSTREAK = 4
) (
  input logic  i_clk,
  input logic  i_rst_n,
  mem_arb_if.slave bus
);

  state_e      state_q;
  own_e        own_q;
  logic        vld_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;

  logic idle, gnt_if, gnt_d, rsp;

  assign idle = (state_q == IDLE);

  mem_arb_pick #(.DSTREAK(DSTREAK)) u_pick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_idle   (idle),
    .i_if_req (bus.i_if_req),
    .i_d_req  (bus.i_d_req),
    .o_gnt_if (gnt_if),
    .o_gnt_d  (gnt_d)
  );

  // FSM plus capture registers; memory-side outputs come straight from here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      own_q   <= OWN_IF;
      vld_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_d) begin
            state_q <= REQ;
            own_q   <= OWN_D;
            vld_q   <= 1'b1;
            we_q    <= bus.i_d_we;
            addr_q  <= {bus.i_d_addr[31:2], 2'b00};
            wdata_q <= bus.i_d_wdata;
            mask_q  <= bus.i_d_we ? bus.i_d_mask : READ_MASK;
          end else if (gnt_if) begin
            state_q <= REQ;
            own_q   <= OWN_IF;
            vld_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= {bus.i_if_addr[31:2], 2'b00};
            wdata_q <= '0;
            mask_q  <= READ_MASK;
          end
        end
        REQ: begin
          // Writes complete on acceptance; reads wait for the response.
          if (bus.i_mem_rdy) begin
            vld_q   <= 1'b0;
            state_q <= we_q ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.i_mem_rvld) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response routing: rvld only counts while a read is outstanding.
  assign rsp            = (state_q == WAIT) && bus.i_mem_rvld;
  assign bus.o_if_rvld  = rsp && (own_q == OWN_IF);
  assign bus.o_d_rvld   = rsp && (own_q == OWN_D);
  assign bus.o_if_rdata = bus.o_if_rvld ? bus.i_mem_rdata : '0;
  assign bus.o_d_rdata  = bus.o_d_rvld  ? bus.i_mem_rdata : '0;

  assign bus.o_if_rdy    = gnt_if;
  assign bus.o_d_rdy     = gnt_d;
  assign bus.o_mem_vld   = vld_q;
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;
  assign bus.o_busy      = !idle;

endmodule
